// File: rtl/pixel_luma_pipe_if.sv
// Video stream bundle: packed pixel plus the three timing strobes that must stay aligned with it.
interface pixel_luma_pipe_if #(
    parameter int CH_WIDTH = 8
);
    logic [3*CH_WIDTH-1:0] data;
    logic                  hsync;
    logic                  vsync;
    logic                  vde;

    modport master (output data, hsync, vsync, vde);
    modport slave  (input  data, hsync, vsync, vde);
endinterface

// File: rtl/pixel_luma_pipe.sv
// Three-stage RGB-to-luma pipe with frame-synchronous output modes and a per-frame luma accumulator.
// Pixels are packed {red, blue, green}; mode and threshold travel with each pixel.
module pixel_luma_pipe #(
    parameter int CH_WIDTH   = 8,
    parameter int COEF_WIDTH = 9,
    parameter int R_COEF     = 77,
    parameter int G_COEF     = 150,
    parameter int B_COEF     = 29,
    parameter int SUM_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_luma_pipe_if.slave      i_vid,
    input  logic [1:0]            i_mode,
    input  logic [CH_WIDTH-1:0]   i_threshold,
    pixel_luma_pipe_if.master     o_vid,
    output logic [SUM_WIDTH-1:0]  o_luma_sum,
    output logic                  o_sum_valid
);

    localparam int PIX_W     = 3 * CH_WIDTH;
    localparam int PROD_W    = CH_WIDTH + COEF_WIDTH;
    localparam int RND_W     = PROD_W + 2;
    localparam int YF_W      = RND_W - 8;
    localparam int ACC_EXT_W = SUM_WIDTH + 1;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_GREY   = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;
    localparam logic [1:0] MODE_INV    = 2'd3;

    localparam logic [COEF_WIDTH-1:0] R_C     = COEF_WIDTH'(R_COEF);
    localparam logic [COEF_WIDTH-1:0] G_C     = COEF_WIDTH'(G_COEF);
    localparam logic [COEF_WIDTH-1:0] B_C     = COEF_WIDTH'(B_COEF);
    localparam logic [CH_WIDTH-1:0]   Y_MAX   = {CH_WIDTH{1'b1}};
    localparam logic [CH_WIDTH-1:0]   THR_RST = {1'b1, {(CH_WIDTH-1){1'b0}}};
    localparam logic [SUM_WIDTH-1:0]  SUM_MAX = {SUM_WIDTH{1'b1}};

    logic [CH_WIDTH-1:0] in_r, in_g, in_b;

    assign in_r = i_vid.data[3*CH_WIDTH-1 -: CH_WIDTH];
    assign in_b = i_vid.data[2*CH_WIDTH-1 -: CH_WIDTH];
    assign in_g = i_vid.data[CH_WIDTH-1:0];

    // Shadowed controls: only a vsync rising edge may change them.
    logic                vsync_prev;
    logic [1:0]          act_mode;
    logic [CH_WIDTH-1:0] act_thr;
    logic                vs_rise_in;

    assign vs_rise_in = i_vid.vsync & ~vsync_prev;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            vsync_prev <= 1'b0;
            act_mode   <= MODE_PASS;
            act_thr    <= THR_RST;
        end else begin
            vsync_prev <= i_vid.vsync;
            if (vs_rise_in) begin
                act_mode <= i_mode;
                act_thr  <= i_threshold;
            end
        end
    end

    // Stage 1: full-width products plus the side-band carried with the pixel.
    logic [PROD_W-1:0]   s1_pr, s1_pg, s1_pb;
    logic [PIX_W-1:0]    s1_pix;
    logic                s1_hs, s1_vs, s1_vde;
    logic [1:0]          s1_mode;
    logic [CH_WIDTH-1:0] s1_thr;

    always_ff @(posedge clk) begin
        // NOTE: the whole datapath is reset, not only control, so outputs read 0 one cycle into reset.
        if (rst) begin
            s1_pr   <= '0;
            s1_pg   <= '0;
            s1_pb   <= '0;
            s1_pix  <= '0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_vde  <= 1'b0;
            s1_mode <= MODE_PASS;
            s1_thr  <= '0;
        end else begin
            s1_pr   <= PROD_W'(in_r) * PROD_W'(R_C);
            s1_pg   <= PROD_W'(in_g) * PROD_W'(G_C);
            s1_pb   <= PROD_W'(in_b) * PROD_W'(B_C);
            s1_pix  <= i_vid.data;
            s1_hs   <= i_vid.hsync;
            s1_vs   <= i_vid.vsync;
            s1_vde  <= i_vid.vde;
            s1_mode <= act_mode;
            s1_thr  <= act_thr;
        end
    end

    // Stage 2 arithmetic: round half up, then clamp for over-unity coefficient sets.
    logic [RND_W-1:0]    rnd_sum;
    logic [YF_W-1:0]     y_full;
    logic [CH_WIDTH-1:0] y_calc;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rnd_sum = RND_W'(s1_pr) + RND_W'(s1_pg) + RND_W'(s1_pb) + RND_W'(128);
        y_full  = YF_W'(rnd_sum >> 8);
        y_calc  = Y_MAX;
        if (y_full <= YF_W'(Y_MAX))
            y_calc = y_full[CH_WIDTH-1:0];
    end

    logic [CH_WIDTH-1:0] s2_y;
    logic [PIX_W-1:0]    s2_pix;
    logic                s2_hs, s2_vs, s2_vde;
    logic [1:0]          s2_mode;
    logic [CH_WIDTH-1:0] s2_thr;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_y    <= '0;
            s2_pix  <= '0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
            s2_vde  <= 1'b0;
            s2_mode <= MODE_PASS;
            s2_thr  <= '0;
        end else begin
            s2_y    <= y_calc;
            s2_pix  <= s1_pix;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_vde  <= s1_vde;
            s2_mode <= s1_mode;
            s2_thr  <= s1_thr;
        end
    end

    // Frame accumulator runs alongside stage 2; s2_vs holds the previous stage-2 vsync.
    logic [SUM_WIDTH-1:0] acc;
    logic [ACC_EXT_W-1:0] acc_ext;
    logic [SUM_WIDTH-1:0] acc_sat;
    logic                 vs_rise_s2;

    assign vs_rise_s2 = s1_vs & ~s2_vs;

    always_comb begin
        acc_ext = {1'b0, acc} + ACC_EXT_W'(y_calc);
        acc_sat = acc_ext[SUM_WIDTH] ? SUM_MAX : acc_ext[SUM_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            o_luma_sum  <= '0;
            o_sum_valid <= 1'b0;
        end else begin
            o_sum_valid <= vs_rise_s2;
            if (vs_rise_s2) begin
                o_luma_sum <= acc;
                acc        <= s1_vde ? SUM_WIDTH'(y_calc) : '0;
            end else if (s1_vde) begin
                acc <= acc_sat;
            end
        end
    end

    // Stage 3: output select by the mode tag that entered with this pixel.
    logic [PIX_W-1:0] out_next;

    always_comb begin
        out_next = s2_pix;
        case (s2_mode)
            MODE_GREY:   out_next = {3{s2_y}};
            MODE_THRESH: out_next = (s2_y >= s2_thr) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            MODE_INV:    out_next = {3{~s2_y}};
            default:     out_next = s2_pix;
        endcase
    end

    logic [PIX_W-1:0] s3_pix;
    logic             s3_hs, s3_vs, s3_vde;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_pix <= '0;
            s3_hs  <= 1'b0;
            s3_vs  <= 1'b0;
            s3_vde <= 1'b0;
        end else begin
            s3_pix <= out_next;
            s3_hs  <= s2_hs;
            s3_vs  <= s2_vs;
            s3_vde <= s2_vde;
        end
    end

    assign o_vid.data  = s3_pix;
    assign o_vid.hsync = s3_hs;
    assign o_vid.vsync = s3_vs;
    assign o_vid.vde   = s3_vde;

endmodule

// File: tb/tb_pixel_luma_pipe.sv
// Directed bench for pixel_luma_pipe: hand-computed pixels checked three cycles after entry,
// plus frame sums on a default instance and a 10-bit accumulator instance sharing the same stream.
module tb_pixel_luma_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_mode;
    logic [7:0]  i_threshold;
    logic [31:0] luma_sum;
    logic        sum_valid;
    logic [9:0]  luma_sum10;
    logic        sum_valid10;

    pixel_luma_pipe_if #(.CH_WIDTH(8)) vin ();
    pixel_luma_pipe_if #(.CH_WIDTH(8)) vout ();
    pixel_luma_pipe_if #(.CH_WIDTH(8)) vout10 ();

    always #5 clk = ~clk;

    pixel_luma_pipe #(.CH_WIDTH(8), .COEF_WIDTH(9), .R_COEF(77), .G_COEF(150), .B_COEF(29),
                      .SUM_WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_vid       (vin),
        .i_mode      (i_mode),
        .i_threshold (i_threshold),
        .o_vid       (vout),
        .o_luma_sum  (luma_sum),
        .o_sum_valid (sum_valid)
    );

    pixel_luma_pipe #(.CH_WIDTH(8), .COEF_WIDTH(9), .R_COEF(77), .G_COEF(150), .B_COEF(29),
                      .SUM_WIDTH(10)) u_dut_sat (
        .clk         (clk),
        .rst         (rst),
        .i_vid       (vin),
        .i_mode      (i_mode),
        .i_threshold (i_threshold),
        .o_vid       (vout10),
        .o_luma_sum  (luma_sum10),
        .o_sum_valid (sum_valid10)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [26:0] h_exp [1024];
    bit          h_chk [1024];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one pixel for one clock; the pixel driven two calls earlier is now at the output.
    task automatic pix(input logic [23:0] d, input logic hs, input logic vs, input logic vde,
                       input logic [23:0] exp_d, input bit chk);
        int idx;
        vin.data  = d;
        vin.hsync = hs;
        vin.vsync = vs;
        vin.vde   = vde;
        h_exp[cyc % 1024] = {exp_d, hs, vs, vde};
        h_chk[cyc % 1024] = chk;
        @(posedge clk);
        #1;
        if (cyc >= 2) begin
            idx = (cyc - 2) % 1024;
            if (h_chk[idx])
                check($sformatf("pix%0d", cyc - 2),
                      64'({vout.data, vout.hsync, vout.vsync, vout.vde}), 64'(h_exp[idx]));
        end
        cyc++;
    endtask

    task automatic sum_chk(input string tag, input logic valid_exp, input logic [31:0] sum_exp);
        check({tag, "_valid"}, 64'(sum_valid), 64'(valid_exp));
        if (valid_exp)
            check({tag, "_sum"}, 64'(luma_sum), 64'(sum_exp));
    endtask

    task automatic zero_chk(input string tag);
        check({tag, "_data"}, 64'(vout.data), 64'h0);
        check({tag, "_sync"}, 64'({vout.hsync, vout.vsync, vout.vde}), 64'h0);
        check({tag, "_sum"},  64'(luma_sum), 64'h0);
        check({tag, "_valid"}, 64'(sum_valid), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        i_mode      = 2'd0;
        i_threshold = 8'd128;
        vin.data    = '0;
        vin.hsync   = 1'b0;
        vin.vsync   = 1'b0;
        vin.vde     = 1'b0;

        for (int i = 0; i < 3; i++) pix(24'h0, 0, 0, 0, 24'h0, 0);
        zero_chk("reset");
        rst = 1'b0;

        // Frame 1: grey requested at the vsync edge; the edge pixel still passes through.
        i_mode = 2'd1;
        pix(24'h000000, 0, 1, 0, 24'h000000, 1);
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        pix(24'hFF0000, 1, 0, 1, 24'h4D4D4D, 1);
        pix(24'h00FF00, 0, 0, 1, 24'h1D1D1D, 1);
        pix(24'h0000FF, 1, 0, 1, 24'h959595, 1);
        // Inverted grey requested mid-frame: must not take effect yet.
        i_mode = 2'd3;
        pix(24'hFF0000, 0, 0, 1, 24'h4D4D4D, 1);
        pix(24'h0000FF, 1, 0, 0, 24'h959595, 1);
        pix(24'hFF0000, 0, 1, 0, 24'h4D4D4D, 1);
        sum_chk("f1_early", 1'b0, 32'd0);

        // Frame 2: inverted grey. Frame 1 sum = 255+77+29+149+77 = 587.
        pix(24'hFF0000, 0, 0, 1, 24'hB2B2B2, 1);
        sum_chk("f1", 1'b1, 32'd587);
        pix(24'hFFFFFF, 0, 0, 1, 24'h000000, 1);
        sum_chk("f1_pulse_end", 1'b0, 32'd0);
        pix(24'h0000FF, 0, 0, 1, 24'h6A6A6A, 1);

        // Frame 3: threshold 100. Frame 2 sum = 77+255+149 = 481.
        i_mode      = 2'd2;
        i_threshold = 8'd100;
        pix(24'h000000, 0, 1, 0, 24'hFFFFFF, 1);
        pix(24'hFF0000, 0, 0, 1, 24'h000000, 1);
        sum_chk("f2", 1'b1, 32'd481);
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        pix(24'h646464, 0, 0, 1, 24'hFFFFFF, 1);
        pix(24'h636363, 0, 0, 1, 24'h000000, 1);

        // Frame 4: grey, 4 white active + 2 white blanking. Frame 3 sum = 77+255+100+99 = 531.
        i_mode = 2'd1;
        pix(24'h000000, 0, 1, 0, 24'h000000, 1);
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        sum_chk("f3", 1'b1, 32'd531);
        for (int i = 0; i < 3; i++) pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        for (int i = 0; i < 2; i++) pix(24'hFFFFFF, 0, 0, 0, 24'hFFFFFF, 1);
        pix(24'h000000, 0, 1, 0, 24'h000000, 1);
        sum_chk("f4_early", 1'b0, 32'd0);

        // Frame 5: all zeros, closed by an active white pixel on the vsync edge.
        pix(24'h000000, 0, 0, 1, 24'h000000, 1);
        sum_chk("f4", 1'b1, 32'd1020);
        check("f4_sat_sum", 64'(luma_sum10), 64'd1020);
        pix(24'h000000, 0, 0, 1, 24'h000000, 1);
        sum_chk("f4_pulse_end", 1'b0, 32'd0);
        pix(24'h000000, 0, 0, 1, 24'h000000, 1);
        pix(24'hFFFFFF, 0, 1, 1, 24'hFFFFFF, 1);

        // Frame 6: edge pixel + 7 white = 8 white -> 2040, and 1023 in the 10-bit instance.
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        sum_chk("f5", 1'b1, 32'd0);
        for (int i = 0; i < 6; i++) pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);

        // Back-to-back vsync edges two cycles apart; the second switches to threshold mode.
        pix(24'h000000, 0, 1, 0, 24'h000000, 1);
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        sum_chk("f6", 1'b1, 32'd2040);
        check("f6_sat_sum", 64'(luma_sum10), 64'd1023);
        check("f6_sat_valid", 64'(sum_valid10), 64'd1);
        i_mode = 2'd2;
        pix(24'h000000, 0, 1, 0, 24'h000000, 1);
        sum_chk("b2b_gap", 1'b0, 32'd0);
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        sum_chk("b2b", 1'b1, 32'd255);
        check("b2b_sat_sum", 64'(luma_sum10), 64'd255);
        pix(24'hFFFFFF, 0, 0, 1, 24'hFFFFFF, 1);
        sum_chk("b2b_pulse_end", 1'b0, 32'd0);
        pix(24'hFFFFFF, 0, 0, 1, 24'h000000, 0);
        pix(24'hFFFFFF, 0, 0, 1, 24'h000000, 0);

        // Reset mid-stream with threshold mode active.
        rst = 1'b1;
        pix(24'hFFFFFF, 0, 0, 1, 24'h000000, 0);
        zero_chk("midrst");
        pix(24'hFFFFFF, 0, 0, 1, 24'h000000, 0);
        rst = 1'b0;
        pix(24'h123456, 1, 0, 1, 24'h123456, 1);
        check("post_rst0_data", 64'(vout.data), 64'h0);
        pix(24'h000000, 0, 0, 0, 24'h000000, 0);
        check("post_rst1_data", 64'(vout.data), 64'h0);
        pix(24'h000000, 0, 0, 0, 24'h000000, 0);
        pix(24'h000000, 0, 0, 0, 24'h000000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
